espectro_seq: RTL and testbench
===============================

# espectro_seq

Note sequencer for the espectro sound generator. The J1 CPU preloads a small buffer of notes over the memory-mapped I/O bus; each note is a 32-bit frequency word plus a duration in milliseconds. On start, the block plays the notes back-to-back by driving the generator's `fr`, `enable` and `init` inputs. It replaces direct CPU writes to the generator, so a whole melody plays without CPU involvement.

## Interface

Parameters:
- `DEPTH`, 8: note buffer entries; power of two, 2..16.
- `TICK_DIV`, 50000: clk cycles per duration tick (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock (`clk50` domain).
- `rst` in 1: synchronous, active-high reset.
- `d_in` in 16: CPU write data.
- `cs` in 1: peripheral select.
- `addr` in 4: 4 LSB of the J1 I/O address.
- `rd` in 1: CPU read strobe.
- `wr` in 1: CPU write strobe.
- `d_out` out 16: registered read data.
- `tone_fr` out 32: frequency word to the generator.
- `tone_en` out 1: generator enable.
- `tone_init` out 1: one-cycle generator re-init pulse.
- `busy` out 1: high while the state is not IDLE.
- `done_irq` out 1: sticky end-of-sequence flag.

## Operation

Register map. All registers are written on posedge clk when `cs && wr`.
- 0x0 FRH: `stage_fr[31:16]`.
- 0x2 FRL: `stage_fr[15:0]`.
- 0x4 DUR, write: appends `{stage_fr, d_in}` at `buf[wr_idx]` and increments `wr_idx`.
  - If `wr_idx==DEPTH`, the write is dropped and sticky `ovf` is set.
  - Appending while playing is allowed.
- 0x6 CTRL, write: bit0 START, bit1 STOP, bit2 LOOP (stored only when the macro is present). STOP has priority over START.
- 0x8 STATUS, read: `{wr_idx[4:0], play_idx[4:0], 2'b0, ovf, empty, busy, done_irq}`. Reading STATUS clears `done_irq` and `ovf`.
- Any other address reads 0; writes to it are ignored.

State machine (IDLE, LOAD, PLAY, DONE):
- IDLE:
  - START with `wr_idx>0` → LOAD, `play_idx=0`, `done_irq` cleared.
  - START with an empty buffer is ignored.
- LOAD, one cycle:
  - `tone_fr<=buf[play_idx].fr`; `tone_init=1`; `tick_cnt` and `ms_cnt` reloaded.
  - → PLAY.
- PLAY:
  - `tone_en=1` unless the note's fr==0 (rest: `tone_en=0`, `tone_fr` still updated).
  - When `ms_cnt==dur`, `play_idx++`, then:
    - if `play_idx<wr_idx`, with this cycle's DUR append counted → LOAD;
    - otherwise → DONE.
  - A dur==0 note stays in PLAY exactly one cycle.
- DONE, one cycle:
  - `tone_en=0`, `done_irq=1`, `wr_idx=play_idx=0` (buffer consumed).
  - → IDLE.

General rules:
- STOP in any state: immediate IDLE, `tone_en=0`, buffer flushed, `done_irq` unchanged.
- START while busy is ignored.
- `tone_fr` holds its last value in IDLE.
- Reset values: `tone_fr=0`, `tone_en=0`, `tone_init=0`, `busy=0`, `done_irq=0`, `d_out=0`, `wr_idx=play_idx=0`, `ovf=0`, LOOP=0, state IDLE.
- Reset mid-note behaves identically to power-on reset.

## Timing

- Register writes take effect at the next posedge.
- `d_out` is valid one cycle after `cs && rd` and holds between reads.
- START at edge N: LOAD in cycle N+1 (`tone_init` high), PLAY from N+2.
- Each note occupies 1 + 1 + dur×TICK_DIV cycles: LOAD, the terminal-compare cycle, then the ticks.
  - There is no gap cycle between consecutive notes beyond LOAD.
- `tone_en` never drops between consecutive non-rest notes; only `tone_init` pulses.
- `done_irq` rises on the cycle after the DONE state.

## Configuration

- `ESPECTRO_SEQ_LOOP_EN` defined:
  - CTRL bit2 sets LOOP.
  - With LOOP=1, end of list gives `play_idx=0` → LOAD instead of DONE. Entries are not consumed and `done_irq` never sets.
  - Playback continues until STOP; clearing LOOP mid-play ends the sequence after the current pass.
- Macro undefined: bit2 is ignored and reads back 0; no LOOP register exists.

## Structure

- Package `espectro_seq_pkg`:
  - State encoding.
  - Address constants `ADDR_FRH/FRL/DUR/CTRL/STATUS`.
  - STATUS and CTRL bit positions.
  - Entry width of 48.
- Sub-module `espectro_seq_tick`: prescaler producing a one-cycle `tick` every `TICK_DIV` clocks, with synchronous clear driven on LOAD.
- Buffer: DEPTH×48 register array. No RAM inference is required.

## Test plan

All scenarios use `TICK_DIV=4`.
- Notes {0x12345678, dur 2} and {0x0000ABCD, dur 1}, then START:
  - `tone_init` pulses twice;
  - `tone_fr` follows the two values for 10 and 6 cycles;
  - `done_irq`=1 and `busy`=0 at the end.
- 9 DUR writes with DEPTH=8 → STATUS shows `wr_idx`=8 and `ovf`=1; STATUS read again → `ovf`=0.
- Rest entry fr=0, dur 3 → `tone_en`=0 for 14 cycles; `done_irq` sets.
- STOP two cycles after START → `tone_en`=0 next cycle; `wr_idx`=0; `done_irq`=0.
- DUR append in the same cycle as the last note's terminal compare → the appended note plays, with no DONE in between.
- With `ESPECTRO_SEQ_LOOP_EN`, LOOP=1 and 2 notes → after the 2nd note, `tone_fr` returns to note 0 and `done_irq` stays 0; STOP → IDLE.

Source files
------------

// File: rtl/espectro_seq_pkg.sv
// Shared types and constants for the espectro note sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package espectro_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_FRH    = 4'h0;
    localparam logic [3:0] ADDR_FRL    = 4'h2;
    localparam logic [3:0] ADDR_DUR    = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h6;
    localparam logic [3:0] ADDR_STATUS = 4'h8;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;

    localparam int STAT_DONE_IRQ = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_OVF      = 3;

    localparam int ENTRY_W = 48;

    typedef struct packed {
        logic [31:0] fr;
        logic [15:0] dur;
    } entry_t;

    // STATUS word layout: {wr_idx, play_idx, 2'b0, ovf, empty, busy, done_irq}
    function automatic logic [15:0] pack_status(input logic [4:0] wr_idx,
                                                input logic [4:0] play_idx,
                                                input logic       ovf,
                                                input logic       empty,
                                                input logic       busy,
                                                input logic       done_irq);
        logic [15:0] s;
        s                = '0;
        s[15:11]         = wr_idx;
        s[10:6]          = play_idx;
        s[STAT_OVF]      = ovf;
        s[STAT_EMPTY]    = empty;
        s[STAT_BUSY]     = busy;
        s[STAT_DONE_IRQ] = done_irq;
        return s;
    endfunction

endpackage

// File: rtl/espectro_seq_tick.sv
// Duration prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr.
// Latency: first tick TICK_DIV cycles after clr is released.
// Backpressure: none; free-running apart from clr.
module espectro_seq_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    // count up, wrap on tick, restart on clr
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/espectro_seq.sv
// Note sequencer: plays a CPU-preloaded {fr, dur} list on the espectro generator (LOOP under ESPECTRO_SEQ_LOOP_EN).
// Latency: START at edge N -> LOAD (tone_init) in N+1, PLAY from N+2; d_out valid one cycle after cs&&rd.
// Backpressure: none; DUR writes past DEPTH are dropped and flagged in ovf.
module espectro_seq
    import espectro_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic [31:0] tone_fr,
    output logic        tone_en,
    output logic        tone_init,
    output logic        busy,
    output logic        done_irq
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_W5 = 5'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] stage_fr_q, stage_fr_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [4:0]  play_idx_q, play_idx_d;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [31:0] tone_fr_q, tone_fr_d;
    logic        tone_en_q, tone_en_d;
    logic        done_irq_q, done_irq_d;
    logic        ovf_q, ovf_d;
    logic [15:0] d_out_q, d_out_d;
    entry_t      note_buf_q [DEPTH];
    entry_t      note_buf_d [DEPTH];

    logic        wr_en, rd_en, wr_dur, app_ok, ctrl_wr, start, stop;
    logic [4:0]  wr_idx_app, play_nxt;
    entry_t      cur;
    logic        tick, loop_on;
    logic [15:0] status_w, ctrl_rb;

    assign wr_en      = cs && wr;
    assign rd_en      = cs && rd;
    assign wr_dur     = wr_en && (addr == ADDR_DUR);
    assign app_ok     = wr_dur && (wr_idx_q != DEPTH_W5);
    assign ctrl_wr    = wr_en && (addr == ADDR_CTRL);
    assign start      = ctrl_wr && d_in[CTRL_START];
    assign stop       = ctrl_wr && d_in[CTRL_STOP];
    // end-of-note compare must see a DUR landing in the same cycle
    assign wr_idx_app = wr_idx_q + {4'b0, app_ok};
    assign play_nxt   = play_idx_q + 5'd1;
    assign cur        = note_buf_q[play_idx_q[IDX_W-1:0]];
    assign status_w   = pack_status(wr_idx_q, play_idx_q, ovf_q, (wr_idx_q == 5'd0),
                                    busy, done_irq_q);
    assign ctrl_rb    = {13'b0, loop_on, 2'b0};

    espectro_seq_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_LOAD),
        .tick (tick)
    );

`ifdef ESPECTRO_SEQ_LOOP_EN
    logic loop_q, loop_d;

    // LOOP follows bit2 of every CTRL write
    always_comb begin
        loop_d = loop_q;
        if (ctrl_wr) begin
            loop_d = d_in[CTRL_LOOP];
        end
    end

    // LOOP register
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q <= 1'b0;
        end else begin
            loop_q <= loop_d;
        end
    end

    assign loop_on = loop_q;
`else
    assign loop_on = 1'b0;
`endif

    // note buffer append; entries are never cleared, only the indices are
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            note_buf_d[i] = note_buf_q[i];
        end
        if (app_ok) begin
            note_buf_d[wr_idx_q[IDX_W-1:0]] = '{fr: stage_fr_q, dur: d_in};
        end
    end

    // note buffer storage (no reset needed: only read below wr_idx)
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            note_buf_q[i] <= note_buf_d[i];
        end
    end

    // register file access plus sequencer next-state logic
    always_comb begin
        state_d    = state_q;
        stage_fr_d = stage_fr_q;
        wr_idx_d   = wr_idx_app;
        play_idx_d = play_idx_q;
        ms_cnt_d   = ms_cnt_q;
        tone_fr_d  = tone_fr_q;
        tone_en_d  = tone_en_q;
        done_irq_d = done_irq_q;
        ovf_d      = ovf_q;
        d_out_d    = d_out_q;

        if (rd_en) begin
            if (addr == ADDR_STATUS) begin
                d_out_d    = status_w;
                done_irq_d = 1'b0;
                ovf_d      = 1'b0;
            end else if (addr == ADDR_CTRL) begin
                d_out_d = ctrl_rb;
            end else begin
                d_out_d = '0;
            end
        end

        // a new overflow wins over a same-cycle read clear
        if (wr_dur && !app_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_en && (addr == ADDR_FRH)) begin
            stage_fr_d[31:16] = d_in;
        end
        if (wr_en && (addr == ADDR_FRL)) begin
            stage_fr_d[15:0] = d_in;
        end

        if (stop) begin
            state_d    = ST_IDLE;
            tone_en_d  = 1'b0;
            wr_idx_d   = '0;
            play_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (wr_idx_q != 5'd0)) begin
                        state_d    = ST_LOAD;
                        play_idx_d = '0;
                        done_irq_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    tone_fr_d = cur.fr;
                    tone_en_d = (cur.fr != 32'd0);
                    ms_cnt_d  = '0;
                    state_d   = ST_PLAY;
                end
                ST_PLAY: begin
                    if (ms_cnt_q == cur.dur) begin
                        play_idx_d = play_nxt;
                        if (play_nxt < wr_idx_app) begin
                            state_d = ST_LOAD;
                        end else if (loop_on) begin
                            play_idx_d = '0;
                            state_d    = ST_LOAD;
                        end else begin
                            tone_en_d = 1'b0;
                            state_d   = ST_DONE;
                        end
                    end else if (tick) begin
                        ms_cnt_d = ms_cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    done_irq_d = 1'b1;
                    wr_idx_d   = '0;
                    play_idx_d = '0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // state and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stage_fr_q <= '0;
            wr_idx_q   <= '0;
            play_idx_q <= '0;
            ms_cnt_q   <= '0;
            tone_fr_q  <= '0;
            tone_en_q  <= 1'b0;
            done_irq_q <= 1'b0;
            ovf_q      <= 1'b0;
            d_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            stage_fr_q <= stage_fr_d;
            wr_idx_q   <= wr_idx_d;
            play_idx_q <= play_idx_d;
            ms_cnt_q   <= ms_cnt_d;
            tone_fr_q  <= tone_fr_d;
            tone_en_q  <= tone_en_d;
            done_irq_q <= done_irq_d;
            ovf_q      <= ovf_d;
            d_out_q    <= d_out_d;
        end
    end

    assign d_out     = d_out_q;
    assign tone_fr   = tone_fr_q;
    assign tone_en   = tone_en_q;
    assign tone_init = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign done_irq  = done_irq_q;

endmodule

// File: tb/tb_espectro_seq.sv
// Bench for espectro_seq: directed scenarios plus random register traffic against a note-timeline model.
// Latency: model outputs are compared at every negedge once reset has been applied.
// Backpressure: none.
module tb_espectro_seq;
    localparam int DEPTH = 8;
    localparam int TD    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic [31:0] tone_fr;
    logic        tone_en, tone_init, busy, done_irq;

    espectro_seq #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .cs        (cs),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .d_out     (d_out),
        .tone_fr   (tone_fr),
        .tone_en   (tone_en),
        .tone_init (tone_init),
        .busy      (busy),
        .done_irq  (done_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: notes as timelines of 2+dur*TD cycles
    logic [31:0] m_fr_buf [DEPTH];
    logic [15:0] m_dur_buf [DEPTH];
    int          m_wr, m_pidx, m_mode, m_pos;   // mode 0 idle, 1 note, 2 end cycle
    bit          m_ovf, m_done, m_loop, m_en;
    logic [31:0] m_fr, m_stage;
    logic [15:0] m_dout;

    always @(posedge clk) begin
        if (rst) begin
            m_wr = 0; m_pidx = 0; m_mode = 0; m_pos = 0;
            m_ovf = 0; m_done = 0; m_loop = 0; m_en = 0;
            m_fr = '0; m_stage = '0; m_dout = '0;
        end else begin : mdl
            bit we, re, app, start, stop;
            int nwr, len;
            logic [15:0] stat;
            we = cs && wr;
            re = cs && rd;
            stat = {5'(m_wr), 5'(m_pidx), 2'b0, m_ovf, (m_wr == 0), (m_mode != 0), m_done};
            if (re) begin
                if (addr == 4'h8) begin
                    m_dout = stat; m_done = 0; m_ovf = 0;
                end else if (addr == 4'h6) m_dout = {13'b0, m_loop, 2'b0};
                else m_dout = '0;
            end
            app = 0;
            if (we && addr == 4'h0) m_stage[31:16] = d_in;
            if (we && addr == 4'h2) m_stage[15:0] = d_in;
            if (we && addr == 4'h4) begin
                if (m_wr < DEPTH) begin
                    m_fr_buf[m_wr] = m_stage; m_dur_buf[m_wr] = d_in; app = 1;
                end else m_ovf = 1;
            end
            nwr   = m_wr + int'(app);
            start = we && addr == 4'h6 && d_in[0];
            stop  = we && addr == 4'h6 && d_in[1];
`ifdef ESPECTRO_SEQ_LOOP_EN
            if (we && addr == 4'h6) m_loop = d_in[2];
`endif
            if (stop) begin
                m_mode = 0; m_en = 0; nwr = 0; m_pidx = 0;
            end else if (m_mode == 0) begin
                if (start && m_wr > 0) begin
                    m_mode = 1; m_pos = 0; m_pidx = 0; m_done = 0;
                end
            end else if (m_mode == 1) begin
                len = 2 + int'(m_dur_buf[m_pidx]) * TD;
                if (m_pos == 0) begin
                    m_fr = m_fr_buf[m_pidx]; m_en = (m_fr != 0); m_pos = 1;
                end else if (m_pos == len - 1) begin
                    m_pidx++;
                    if (m_pidx < nwr) m_pos = 0;
                    else if (m_loop) begin m_pidx = 0; m_pos = 0; end
                    else begin m_mode = 2; m_en = 0; end
                end else m_pos++;
            end else begin
                m_done = 1; nwr = 0; m_pidx = 0; m_mode = 0;
            end
            m_wr = nwr;
        end
    end

    // every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tone_fr", tone_fr, m_fr);
            chk("tone_en", 32'(tone_en), 32'(m_en));
            chk("tone_init", 32'(tone_init), 32'(m_mode == 1 && m_pos == 0));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("done_irq", 32'(done_irq), 32'(m_done));
            chk("d_out", 32'(d_out), 32'(m_dout));
        end
    end

    // ---------------- stimulus helpers (called right after a negedge)
    int o_init, o_busy, o_en, o_fa, o_fb;

    task automatic idle(input int n);
        cs = 0; wr = 0; rd = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wreg(input logic [3:0] a, input logic [15:0] d);
        cs = 1; wr = 1; rd = 0; addr = a; d_in = d;
        @(negedge clk);
        cs = 0; wr = 0;
    endtask

    task automatic rreg(input logic [3:0] a);
        cs = 1; rd = 1; wr = 0; addr = a;
        @(negedge clk);
        cs = 0; rd = 0;
    endtask

    task automatic add_note(input logic [31:0] f, input logic [15:0] d);
        wreg(4'h0, f[31:16]);
        wreg(4'h2, f[15:0]);
        wreg(4'h4, d);
    endtask

    task automatic observe(input int n, input logic [31:0] fa, input logic [31:0] fb);
        o_init = 0; o_busy = 0; o_en = 0; o_fa = 0; o_fb = 0;
        repeat (n) begin
            if (tone_init) o_init++;
            if (busy) o_busy++;
            if (busy && tone_en) o_en++;
            if (busy && tone_fr == fa) o_fa++;
            if (busy && tone_fr == fb) o_fb++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        @(negedge clk);
        chk_en = 1;
        idle(2);
        rst = 0;
        chk("rst_fr", tone_fr, 32'h0);
        chk("rst_en", 32'(tone_en), 32'h0);
        chk("rst_init", 32'(tone_init), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done_irq), 32'h0);
        chk("rst_dout", 32'(d_out), 32'h0);
        idle(1);

        // two-note melody
        add_note(32'h12345678, 16'd2);
        add_note(32'h0000ABCD, 16'd1);
        fork
            observe(26, 32'h12345678, 32'h0000ABCD);
            wreg(4'h6, 16'h0001);
        join
        chk("s1_init_pulses", 32'(o_init), 32'd2);
        chk("s1_note0_cycles", 32'(o_fa), 32'd10);
        chk("s1_note1_cycles", 32'(o_fb), 32'd6);
        chk("s1_busy_cycles", 32'(o_busy), 32'd17);
        chk("s1_done", 32'(done_irq), 32'd1);
        chk("s1_busy_end", 32'(busy), 32'd0);

        // overflow
        rreg(4'h8);
        chk("s2_status_pre", 32'(d_out), 32'h0005);
        for (int i = 0; i < 9; i++) wreg(4'h4, 16'(i));
        rreg(4'h8);
        chk("s2_status_ovf", 32'(d_out), 32'h4008);
        rreg(4'h8);
        chk("s2_status_clr", 32'(d_out), 32'h4000);
        wreg(4'h6, 16'h0002);
        rreg(4'h8);
        chk("s2_status_flush", 32'(d_out), 32'h0004);

        // rest note
        add_note(32'h0, 16'd3);
        fork
            observe(20, 32'h0, 32'h0);
            wreg(4'h6, 16'h0001);
        join
        chk("s3_busy_cycles", 32'(o_busy), 32'd15);
        chk("s3_en_cycles", 32'(o_en), 32'd0);
        chk("s3_done", 32'(done_irq), 32'd1);
        rreg(4'h8);
        chk("s3_status", 32'(d_out), 32'h0005);

        // STOP two cycles after START
        add_note(32'h11112222, 16'd5);
        add_note(32'h33334444, 16'd5);
        wreg(4'h6, 16'h0001);
        idle(1);
        wreg(4'h6, 16'h0002);
        chk("s4_en_after_stop", 32'(tone_en), 32'd0);
        chk("s4_busy_after_stop", 32'(busy), 32'd0);
        rreg(4'h8);
        chk("s4_status", 32'(d_out), 32'h0004);

        // append lands on the last note's terminal compare
        add_note(32'h00005555, 16'd0);
        wreg(4'h0, 16'h00AA);
        wreg(4'h2, 16'hBBCC);
        fork
            observe(20, 32'h00005555, 32'h00AABBCC);
            begin
                wreg(4'h6, 16'h0001);
                idle(1);
                wreg(4'h4, 16'd1);
            end
        join
        chk("s5_init_pulses", 32'(o_init), 32'd2);
        chk("s5_busy_cycles", 32'(o_busy), 32'd9);
        chk("s5_appended_cycles", 32'(o_fb), 32'd6);
        chk("s5_done", 32'(done_irq), 32'd1);

`ifdef ESPECTRO_SEQ_LOOP_EN
        rreg(4'h8);
        add_note(32'hA0A0A0A0, 16'd1);
        add_note(32'hB0B0B0B0, 16'd1);
        fork
            observe(26, 32'hA0A0A0A0, 32'hB0B0B0B0);
            wreg(4'h6, 16'h0005);
        join
        chk("s6_init_pulses", 32'(o_init), 32'd5);
        chk("s6_note0_cycles", 32'(o_fa), 32'd12);
        chk("s6_note1_cycles", 32'(o_fb), 32'd12);
        chk("s6_done", 32'(done_irq), 32'd0);
        chk("s6_busy", 32'(busy), 32'd1);
        wreg(4'h6, 16'h0002);
        chk("s6_busy_stop", 32'(busy), 32'd0);
`endif

        // random register traffic, including resets mid-note
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 18) wreg(4'h0, ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom));
            else if (r < 36) wreg(4'h2, ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom));
            else if (r < 52) wreg(4'h4, 16'($urandom_range(0, 3)));
            else if (r < 61) wreg(4'h6, {13'b0, ($urandom_range(0, 3) == 0), 2'b01});
            else if (r < 64) wreg(4'h6, 16'($urandom_range(0, 7)) | 16'h0002);
            else if (r < 76) rreg(4'h8);
            else if (r < 80) rreg(4'($urandom_range(0, 15)));
            else if (r < 82) wreg(4'($urandom_range(9, 15)), 16'($urandom));
            else if (r == 99) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
            end else idle(1);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
